reduce_gate_pipe_v: RTL and testbench

REDUCE_GATE_PIPE_V -- requirements
Module: reduce_gate_pipe_v

---
 rtl/reduce_gate_pipe_v_pkg.sv | 30 +++
 rtl/reduce_gate_pipe_v_if.sv | 29 ++
 rtl/reduce_gate_pipe_v_stage.sv | 48 ++++
 rtl/reduce_gate_pipe_v.sv | 69 ++++++
 tb/tb_reduce_gate_pipe_v.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/reduce_gate_pipe_v_pkg.sv
// gate_pkg_v: gate mode encodings, identity elements and tree sizing helpers
// shared by the reduction pipeline, its stages and its interface.
package gate_pkg_v;

    typedef enum logic [1:0] {
        MODE_OR  = 2'b00,
        MODE_AND = 2'b01,
        MODE_XOR = 2'b10,
        MODE_NOR = 2'b11
    } mode_t;

    // NOR reduces as an OR tree, so it shares OR's identity of 0.
    function automatic logic identity(mode_t m);
        return m == MODE_AND;
    endfunction

    function automatic logic combine(mode_t m, logic a, logic b);
        return (m == MODE_AND) ? (a & b) : (m == MODE_XOR) ? (a ^ b) : (a | b);
    endfunction

    function automatic int lat_of(int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

    // Number of live nodes entering tree level k.
    function automatic int stage_w(int w, int k);
        return (w + (1 << k) - 1) >> k;
    endfunction

endpackage

// File: rtl/reduce_gate_pipe_v_if.sv
// reduce_gate_pipe_v_if: beat input, clear and result/accumulator outputs
// of the reduction pipeline.
interface reduce_gate_pipe_v_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    import gate_pkg_v::*;

    logic             i_valid;
    mode_t            i_mode;
    logic [WIDTH-1:0] i_data;
    logic             i_clr;
    logic             o_valid;
    logic             o_f;
    logic             o_acc;
    logic             o_acc_valid;
    logic [CNT_W-1:0] o_cnt;

    modport master (
        output i_valid, i_mode, i_data, i_clr,
        input  o_valid, o_f, o_acc, o_acc_valid, o_cnt
    );

    modport slave (
        input  i_valid, i_mode, i_data, i_clr,
        output o_valid, o_f, o_acc, o_acc_valid, o_cnt
    );

endinterface

// File: rtl/reduce_gate_pipe_v_stage.sv
// reduce_stage_v: one registered tree level, N operands -> ceil(N/2) results,
// with the beat's valid and mode carried alongside.
module reduce_stage_v
    import gate_pkg_v::*;
#(
    parameter int N    = 2,
    parameter bit LAST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  mode_t                in_mode,
    input  logic [N-1:0]         in_data,
    output logic                 out_valid,
    output mode_t                out_mode,
    output logic [(N+1)/2-1:0]   out_data
);
    localparam int M = (N + 1) / 2;

    logic [2*M-1:0] padded;
    logic [M-1:0]   nxt;

    // An odd trailing operand pairs with the mode's identity so it passes through.
    always_comb begin
        padded = {(2*M){identity(in_mode)}};
        padded[N-1:0] = in_data;
        for (int i = 0; i < M; i++)
            nxt[i] = combine(in_mode, padded[2*i], padded[2*i+1]);
        if (LAST && in_mode == MODE_NOR)
            nxt = ~nxt;
    end

    // Data holds between beats so the final stage keeps o_f stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mode  <= MODE_OR;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_mode <= in_mode;
                out_data <= nxt;
            end
        end
    end

endmodule

// File: rtl/reduce_gate_pipe_v.sv
// reduce_gate_pipe_v: pipelined OR/AND/XOR/NOR reduction tree, one register
// per level, with a running accumulator and saturating result counter.
module reduce_gate_pipe_v
    import gate_pkg_v::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    reduce_gate_pipe_v_if.slave bus
);
    localparam int LAT = lat_of(WIDTH);

    for (genvar k = 0; k < LAT; k++) begin : g_lvl
        localparam int IW = stage_w(WIDTH, k);
        localparam int OW = stage_w(WIDTH, k + 1);
        logic          vi;
        mode_t         mi;
        logic [IW-1:0] di;
        logic          v;
        mode_t         m;
        logic [OW-1:0] d;
        if (k == 0) begin : g_in
            assign vi = bus.i_valid;
            assign mi = bus.i_mode;
            assign di = bus.i_data;
        end else begin : g_in
            assign vi = g_lvl[k-1].v;
            assign mi = g_lvl[k-1].m;
            assign di = g_lvl[k-1].d;
        end
        reduce_stage_v #(.N(IW), .LAST(k == LAT - 1)) u_stage (
            .clk      (i_clk),
            .rst      (i_rst),
            .in_valid (vi),
            .in_mode  (mi),
            .in_data  (di),
            .out_valid(v),
            .out_mode (m),
            .out_data (d)
        );
    end

    mode_t f_mode;

    assign bus.o_valid = g_lvl[LAT-1].v;
    assign bus.o_f     = g_lvl[LAT-1].d[0];
    assign f_mode      = g_lvl[LAT-1].m;

    // A clear that meets a result restarts accumulation from that result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_acc       <= 1'b0;
            bus.o_acc_valid <= 1'b0;
            bus.o_cnt       <= '0;
        end else if (bus.o_valid) begin
            bus.o_acc       <= (bus.i_clr || !bus.o_acc_valid) ? bus.o_f
                                                               : combine(f_mode, bus.o_acc, bus.o_f);
            bus.o_acc_valid <= 1'b1;
            bus.o_cnt       <= bus.i_clr ? CNT_W'(1) : bus.o_cnt + CNT_W'(!(&bus.o_cnt));
        end else if (bus.i_clr) begin
            bus.o_acc       <= 1'b0;
            bus.o_acc_valid <= 1'b0;
            bus.o_cnt       <= '0;
        end
    end

endmodule

// File: tb/tb_reduce_gate_pipe_v.sv
// tb_reduce_gate_pipe_v: directed vectors for WIDTH=8, WIDTH=5/CNT_W=2 and
// WIDTH=1 instances of the reduction pipeline.
module tb_reduce_gate_pipe_v;
    import gate_pkg_v::*;

    typedef struct {
        mode_t      mode;
        logic [7:0] data;
        logic       f;
    } vec_t;

    localparam int NV = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vec[NV];

    logic [4:0] d5v[5] = '{5'h1F, 5'h1E, 5'h1F, 5'h0F, 5'h10};
    logic       f5[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    mode_t      m1[5]  = '{MODE_OR, MODE_NOR, MODE_NOR, MODE_AND, MODE_XOR};
    logic       d1v[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       f1[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    reduce_gate_pipe_v_if #(.WIDTH(8), .CNT_W(8)) b8 ();
    reduce_gate_pipe_v_if #(.WIDTH(5), .CNT_W(2)) b5 ();
    reduce_gate_pipe_v_if #(.WIDTH(1), .CNT_W(8)) b1 ();

    reduce_gate_pipe_v #(.WIDTH(8), .CNT_W(8)) d8 (.i_clk(clk), .i_rst(rst), .bus(b8));
    reduce_gate_pipe_v #(.WIDTH(5), .CNT_W(2)) d5 (.i_clk(clk), .i_rst(rst), .bus(b5));
    reduce_gate_pipe_v #(.WIDTH(1), .CNT_W(8)) d1 (.i_clk(clk), .i_rst(rst), .bus(b1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vec[0] = '{MODE_OR,  8'h00, 1'b0};
        vec[1] = '{MODE_OR,  8'h10, 1'b1};
        vec[2] = '{MODE_XOR, 8'h07, 1'b1};
        vec[3] = '{MODE_NOR, 8'h00, 1'b1};
        vec[4] = '{MODE_AND, 8'hFF, 1'b1};
        vec[5] = '{MODE_AND, 8'hFE, 1'b0};
        vec[6] = '{MODE_XOR, 8'h03, 1'b0};
        vec[7] = '{MODE_NOR, 8'h80, 1'b0};
        vec[8] = '{MODE_AND, 8'h7F, 1'b0};
        vec[9] = '{MODE_OR,  8'hFF, 1'b1};
        {b8.i_valid, b8.i_clr, b8.i_data} = '0;
        {b5.i_valid, b5.i_clr, b5.i_data} = '0;
        {b1.i_valid, b1.i_clr, b1.i_data} = '0;
        b8.i_mode = MODE_OR;
        b5.i_mode = MODE_OR;
        b1.i_mode = MODE_OR;
        tick();
        tick();
        check("rst_valid",     b8.o_valid, 0);
        check("rst_f",         b8.o_f, 0);
        check("rst_acc",       b8.o_acc, 0);
        check("rst_acc_valid", b8.o_acc_valid, 0);
        check("rst_cnt",       b8.o_cnt, 0);
        rst = 1'b0;

        // Back-to-back stream with per-beat modes; results lag by exactly 3 cycles.
        for (int i = 0; i < NV + 2; i++) begin
            b8.i_valid = (i < NV);
            if (i < NV) begin
                b8.i_mode = vec[i].mode;
                b8.i_data = vec[i].data;
            end
            tick();
            if (i < 2) check("w8_latency_gap", b8.o_valid, 0);
            else begin
                check("w8_valid", b8.o_valid, 1);
                check("w8_f", b8.o_f, vec[i-2].f);
            end
        end
        tick();
        check("w8_idle_valid", b8.o_valid, 0);
        check("w8_cnt", b8.o_cnt, NV);
        check("w8_acc", b8.o_acc, 1);
        b8.i_mode = MODE_AND;
        b8.i_data = 8'h00;
        tick();
        tick();
        check("w8_f_hold", b8.o_f, 1);

        // Reset with two beats in flight and a coincident valid + clear.
        b8.i_mode = MODE_OR;
        b8.i_data = 8'hFF;
        b8.i_valid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        b8.i_clr = 1'b1;
        tick();
        rst = 1'b0;
        b8.i_valid = 1'b0;
        b8.i_clr = 1'b0;
        check("flush_f",         b8.o_f, 0);
        check("flush_acc",       b8.o_acc, 0);
        check("flush_acc_valid", b8.o_acc_valid, 0);
        check("flush_cnt",       b8.o_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            check("flush_valid", b8.o_valid, 0);
            tick();
        end

        // OR beats 0,0,1,0,0 with a clear landing on the fifth result.
        for (int c = 0; c < 8; c++) begin
            b8.i_valid = (c < 5);
            b8.i_mode = MODE_OR;
            b8.i_data = (c == 2) ? 8'h01 : 8'h00;
            b8.i_clr = (c == 7);
            tick();
            if (c >= 3 && c <= 6) begin
                check("acc_seq_acc", b8.o_acc, (c == 5 || c == 6) ? 1 : 0);
                check("acc_seq_cnt", b8.o_cnt, c - 2);
                check("acc_seq_acc_valid", b8.o_acc_valid, 1);
            end
            if (c == 6) check("acc_seq_valid5", b8.o_valid, 1);
        end
        b8.i_clr = 1'b0;
        check("clr_load_acc", b8.o_acc, 0);
        check("clr_load_cnt", b8.o_cnt, 1);
        check("clr_load_acc_valid", b8.o_acc_valid, 1);

        // Clear alone leaves the pipeline result in place.
        b8.i_data = 8'h80;
        b8.i_valid = 1'b1;
        tick();
        b8.i_valid = 1'b0;
        tick();
        tick();
        tick();
        check("pre_clr_acc", b8.o_acc, 1);
        check("pre_clr_cnt", b8.o_cnt, 2);
        b8.i_clr = 1'b1;
        tick();
        b8.i_clr = 1'b0;
        check("clr_acc",       b8.o_acc, 0);
        check("clr_acc_valid", b8.o_acc_valid, 0);
        check("clr_cnt",       b8.o_cnt, 0);
        check("clr_f_kept",    b8.o_f, 1);

        // WIDTH=5 AND padding, then counter saturation with CNT_W=2.
        b5.i_mode = MODE_AND;
        for (int i = 0; i < 7; i++) begin
            b5.i_valid = (i < 5);
            if (i < 5) b5.i_data = d5v[i];
            tick();
            if (i < 2) check("w5_latency_gap", b5.o_valid, 0);
            else begin
                check("w5_valid", b5.o_valid, 1);
                check("w5_f", b5.o_f, f5[i-2]);
            end
        end
        tick();
        check("w5_cnt_sat", b5.o_cnt, 3);
        check("w5_acc", b5.o_acc, 0);

        // WIDTH=1: single-cycle latency, NOR inverts the lone bit.
        for (int i = 0; i < 5; i++) begin
            b1.i_valid = 1'b1;
            b1.i_mode = m1[i];
            b1.i_data = d1v[i];
            tick();
            check("w1_valid", b1.o_valid, 1);
            check("w1_f", b1.o_f, f1[i]);
        end
        b1.i_valid = 1'b0;
        tick();
        check("w1_idle_valid", b1.o_valid, 0);
        check("w1_cnt", b1.o_cnt, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
